// File: rtl/output_forward.sv
// Output-neuron forward MAC: sums hidden_val*w over N_HIDDEN terms into a saturating 23-bit result.
// Latency N_HIDDEN+2 cycles from start to f_end_o; valid_i low stalls the walk with no timeout.
module output_forward #(
    parameter int N_HIDDEN = 4,
    parameter int IDX_W    = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             clear_i,
    input  logic             valid_i,
    input  logic [9:0]       hidden_val_i,
    input  logic [7:0]       w_i,
    output logic [IDX_W-1:0] idx_o,
    output logic [22:0]      final_o,
    output logic             busy_o,
    output logic             f_end_o
);

    localparam logic [1:0]       S_IDLE   = 2'd0;
    localparam logic [1:0]       S_ACC    = 2'd1;
    localparam logic [1:0]       S_DONE   = 2'd2;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_HIDDEN - 1);
    localparam logic [22:0]      SAT_MAX  = 23'h7FFFFF;

    logic [1:0]       state_q, state_d;
    logic [22:0]      acc_q, acc_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [22:0]      final_q, final_d;
    logic             f_end_q, f_end_d;

    logic [17:0] prod;
    logic [23:0] sum;
    logic [22:0] acc_sat;

    assign prod = {8'd0, hidden_val_i} * {10'd0, w_i};
    assign sum  = {1'b0, acc_q} + {6'd0, prod};
    // Once acc sits at SAT_MAX any further term overflows again, so saturation stays sticky.
    assign acc_sat = sum[23] ? SAT_MAX : sum[22:0];

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        final_d = final_q;
        f_end_d = 1'b0;
        if (clear_i) begin
            state_d = S_IDLE;
            acc_d   = '0;
            idx_d   = '0;
            final_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        acc_d   = '0;
                        idx_d   = '0;
                        state_d = S_ACC;
                    end
                end
                S_ACC: begin
                    if (valid_i) begin
                        acc_d = acc_sat;
                        if (idx_q == IDX_LAST) begin
                            state_d = S_DONE;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    final_d = acc_q;
                    f_end_d = 1'b1;
                    idx_d   = '0;
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            idx_q   <= '0;
            final_q <= '0;
            f_end_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            final_q <= final_d;
            f_end_q <= f_end_d;
        end
    end

    assign idx_o   = idx_q;
    assign final_o = final_q;
    assign busy_o  = (state_q == S_ACC) || (state_q == S_DONE);
    assign f_end_o = f_end_q;

endmodule

// File: tb/tb_output_forward.sv
// Scoreboarded bench for output_forward: N_HIDDEN=4 main instance plus N=40 saturation and N=1 instances.
module tb_output_forward;

    typedef struct {
        logic [22:0] val;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Main instance, N_HIDDEN=4
    logic        start1, clear1, valid1;
    logic [9:0]  hv1 [4];
    logic [7:0]  wv1 [4];
    logic [9:0]  hid1;
    logic [7:0]  w1;
    logic [1:0]  idx1;
    logic [22:0] final1;
    logic        busy1, fend1;

    assign hid1 = hv1[idx1];
    assign w1   = wv1[idx1];

    output_forward #(.N_HIDDEN(4), .IDX_W(2)) dut1 (
        .clk_i(clk), .rst_i(rst_n), .start_i(start1), .clear_i(clear1), .valid_i(valid1),
        .hidden_val_i(hid1), .w_i(w1), .idx_o(idx1), .final_o(final1),
        .busy_o(busy1), .f_end_o(fend1)
    );

    // Saturation instance, N_HIDDEN=40
    logic        start2;
    logic [5:0]  idx2;
    logic [22:0] final2;
    logic        busy2, fend2;

    output_forward #(.N_HIDDEN(40), .IDX_W(6)) dut2 (
        .clk_i(clk), .rst_i(rst_n), .start_i(start2), .clear_i(1'b0), .valid_i(1'b1),
        .hidden_val_i(10'd1023), .w_i(8'd255), .idx_o(idx2), .final_o(final2),
        .busy_o(busy2), .f_end_o(fend2)
    );

    // Single-term instance, N_HIDDEN=1
    logic        start3;
    logic [0:0]  idx3;
    logic [22:0] final3;
    logic        busy3, fend3;

    output_forward #(.N_HIDDEN(1), .IDX_W(1)) dut3 (
        .clk_i(clk), .rst_i(rst_n), .start_i(start3), .clear_i(1'b0), .valid_i(1'b1),
        .hidden_val_i(10'd1023), .w_i(8'd255), .idx_o(idx3), .final_o(final3),
        .busy_o(busy3), .f_end_o(fend3)
    );

    exp_t q1[$];
    exp_t q2[$];
    exp_t q3[$];
    exp_t e1, e2, e3;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitors: every f_end_o pulse must match the head of its queue in value and cycle.
    always @(negedge clk) begin
        if (rst_n && fend1) begin
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL dut1_unexpected_f_end final_o=%0d cycle=%0d", final1, cyc);
            end else begin
                e1 = q1.pop_front();
                if (final1 !== e1.val || cyc != e1.cyc) begin
                    errors++;
                    $display("FAIL dut1_result final_o=%0d at cycle %0d expected %0d at cycle %0d",
                             final1, cyc, e1.val, e1.cyc);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && fend2) begin
            checks++;
            if (q2.size() == 0) begin
                errors++;
                $display("FAIL dut2_unexpected_f_end final_o=%0d cycle=%0d", final2, cyc);
            end else begin
                e2 = q2.pop_front();
                if (final2 !== e2.val || cyc != e2.cyc) begin
                    errors++;
                    $display("FAIL dut2_result final_o=%0h at cycle %0d expected %0h at cycle %0d",
                             final2, cyc, e2.val, e2.cyc);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && fend3) begin
            checks++;
            if (q3.size() == 0) begin
                errors++;
                $display("FAIL dut3_unexpected_f_end final_o=%0d cycle=%0d", final3, cyc);
            end else begin
                e3 = q3.pop_front();
                if (final3 !== e3.val || cyc != e3.cyc) begin
                    errors++;
                    $display("FAIL dut3_result final_o=%0d at cycle %0d expected %0d at cycle %0d",
                             final3, cyc, e3.val, e3.cyc);
                end
            end
        end
    end

    task automatic set_data(input logic [9:0] h0, input logic [9:0] h1,
                            input logic [9:0] h2, input logic [9:0] h3);
        hv1[0] = h0; hv1[1] = h1; hv1[2] = h2; hv1[3] = h3;
    endtask

    // 1*10 + 2*20 + 3*30 + 4*40 = 300, f_end_o in cycle start+6
    task automatic basic_pass(input string tag);
        int c;
        c = cyc;
        start1 = 1'b1;
        q1.push_back('{val: 23'd300, cyc: c + 6});
        @(negedge clk);
        start1 = 1'b0;
        chk({tag, "_busy_during"}, 32'(busy1), 32'd1);
        repeat (6) @(negedge clk);
        chk({tag, "_busy_after"}, 32'(busy1), 32'd0);
        chk({tag, "_final_held"}, 32'(final1), 32'd300);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin : stim
        int c;
        rst_n  = 1'b0;
        start1 = 1'b0;
        clear1 = 1'b0;
        valid1 = 1'b1;
        start2 = 1'b0;
        start3 = 1'b0;
        set_data(10'd1, 10'd2, 10'd3, 10'd4);
        wv1[0] = 8'd10; wv1[1] = 8'd20; wv1[2] = 8'd30; wv1[3] = 8'd40;

        repeat (2) @(negedge clk);
        chk("reset_idx", 32'(idx1), 32'd0);
        chk("reset_final", 32'(final1), 32'd0);
        chk("reset_busy", 32'(busy1), 32'd0);
        chk("reset_f_end", 32'(fend1), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        basic_pass("basic");

        // Two stall cycles after the first term: idx_o holds at 1, result 2 cycles later.
        c = cyc;
        start1 = 1'b1;
        q1.push_back('{val: 23'd300, cyc: c + 8});
        @(negedge clk);
        start1 = 1'b0;
        @(negedge clk);
        chk("stall_idx_before", 32'(idx1), 32'd1);
        valid1 = 1'b0;
        @(negedge clk);
        chk("stall_idx_hold1", 32'(idx1), 32'd1);
        @(negedge clk);
        chk("stall_idx_hold2", 32'(idx1), 32'd1);
        valid1 = 1'b1;
        repeat (5) @(negedge clk);
        chk("stall_final", 32'(final1), 32'd300);
        chk("stall_busy_after", 32'(busy1), 32'd0);

        // Mid-pass start is ignored; start alongside f_end_o launches a zero-data pass.
        c = cyc;
        start1 = 1'b1;
        q1.push_back('{val: 23'd300, cyc: c + 6});
        @(negedge clk);
        start1 = 1'b0;
        repeat (2) @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (2) @(negedge clk);
        chk("b2b_f_end_now", 32'(fend1), 32'd1);
        set_data(10'd0, 10'd0, 10'd0, 10'd0);
        start1 = 1'b1;
        q1.push_back('{val: 23'd0, cyc: cyc + 6});
        @(negedge clk);
        start1 = 1'b0;
        repeat (6) @(negedge clk);
        chk("b2b_final_zero", 32'(final1), 32'd0);
        set_data(10'd1, 10'd2, 10'd3, 10'd4);

        basic_pass("pre_clear");

        // clear_i at idx_o=2 aborts the pass without any f_end_o.
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (2) @(negedge clk);
        chk("clear_idx_at", 32'(idx1), 32'd2);
        clear1 = 1'b1;
        @(negedge clk);
        clear1 = 1'b0;
        chk("clear_busy", 32'(busy1), 32'd0);
        chk("clear_final", 32'(final1), 32'd0);
        chk("clear_idx", 32'(idx1), 32'd0);
        repeat (8) @(negedge clk);

        basic_pass("pre_reset");

        // Asynchronous reset mid-pass.
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("arst_final", 32'(final1), 32'd0);
        chk("arst_busy", 32'(busy1), 32'd0);
        chk("arst_idx", 32'(idx1), 32'd0);
        chk("arst_f_end", 32'(fend1), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);

        // 40 * 1023 * 255 = 10,434,600 saturates to 0x7FFFFF.
        c = cyc;
        start2 = 1'b1;
        q2.push_back('{val: 23'h7FFFFF, cyc: c + 42});
        @(negedge clk);
        start2 = 1'b0;
        repeat (45) @(negedge clk);
        chk("sat_final", 32'(final2), 32'h7FFFFF);
        chk("sat_busy_after", 32'(busy2), 32'd0);

        // Single maximal term: 1023 * 255 = 260865.
        c = cyc;
        start3 = 1'b1;
        q3.push_back('{val: 23'd260865, cyc: c + 3});
        @(negedge clk);
        start3 = 1'b0;
        repeat (4) @(negedge clk);
        chk("one_final", 32'(final3), 32'd260865);
        chk("one_busy_after", 32'(busy3), 32'd0);

        chk("q1_drained", 32'(q1.size()), 32'd0);
        chk("q2_drained", 32'(q2.size()), 32'd0);
        chk("q3_drained", 32'(q3.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
